// File: rtl/rv32i_encode.sv
// RV32I instruction encoder: op index + operands -> 32-bit machine word tagged with its imem address.
// Latency 1 (accept to out_valid); 2-entry output buffer, in_ready = buffer not full (registered only).
module rv32i_encode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_U   = 3'd0;
    localparam logic [2:0] FMT_J   = 3'd1;
    localparam logic [2:0] FMT_I   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_S   = 3'd4;
    localparam logic [2:0] FMT_SH  = 3'd5;
    localparam logic [2:0] FMT_R   = 3'd6;
    localparam logic [2:0] FMT_BAD = 3'd7;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc_word;
    logic        enc_err;

    // Sign-extension checks: upper bits must all equal the sign bit of the field.
    logic i_ok, b_ok, j_ok, sh_ok, u_ok;
    assign i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign b_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign j_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign sh_ok = ~(|in_imm[31:5]);
    assign u_ok  = ~(|in_imm[11:0]);

    always_comb begin
        fmt = FMT_BAD;
        opc = 7'd0;
        f3  = 3'd0;
        f7  = 7'd0;
        case (in_op)
            6'd0:  begin fmt = FMT_U;  opc = OPC_LUI;                end
            6'd1:  begin fmt = FMT_U;  opc = OPC_AUIPC;              end
            6'd2:  begin fmt = FMT_J;  opc = OPC_JAL;                end
            6'd3:  begin fmt = FMT_I;  opc = OPC_JALR;   f3 = 3'd0;  end
            6'd4:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd0;  end
            6'd5:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd1;  end
            6'd6:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd4;  end
            6'd7:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd5;  end
            6'd8:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd6;  end
            6'd9:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd7;  end
            6'd10: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd0;  end
            6'd11: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd1;  end
            6'd12: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd2;  end
            6'd13: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd4;  end
            6'd14: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd5;  end
            6'd15: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd0;  end
            6'd16: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd1;  end
            6'd17: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd2;  end
            6'd18: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd0;  end
            6'd19: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd2;  end
            6'd20: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd3;  end
            6'd21: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd4;  end
            6'd22: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd6;  end
            6'd23: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'd7;  end
            6'd24: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'd1;  end
            6'd25: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'd5;  end
            6'd26: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'd5;  f7 = 7'h20; end
            6'd27: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd0;  end
            6'd28: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd0;  f7 = 7'h20; end
            6'd29: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd1;  end
            6'd30: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd2;  end
            6'd31: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd3;  end
            6'd32: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd4;  end
            6'd33: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd5;  end
            6'd34: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd5;  f7 = 7'h20; end
            6'd35: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd6;  end
            6'd36: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'd7;  end
            default: fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        enc_word = 32'd0;
        enc_err  = 1'b0;
        case (fmt)
            FMT_U:  begin enc_word = {in_imm[31:12], in_rd, opc}; enc_err = ~u_ok; end
            FMT_J:  begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
                enc_err  = ~j_ok;
            end
            FMT_I:  begin enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opc}; enc_err = ~i_ok; end
            FMT_B:  begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
                enc_err  = ~b_ok;
            end
            FMT_S:  begin enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc}; enc_err = ~i_ok; end
            FMT_SH: begin enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc}; enc_err = ~sh_ok; end
            FMT_R:  enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_word = 32'd0;
        end
    end

    entry_t      buf_q [2];
    logic [1:0]  count_q;
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [31:0] addr_q;
    logic        push;
    logic        pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_word  = buf_q[rd_ptr_q].word;
    assign out_addr  = buf_q[rd_ptr_q].addr;
    assign out_err   = buf_q[rd_ptr_q].err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '{word: 32'd0, addr: BASE_ADDR, err: 1'b0};
            end
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            addr_q    <= BASE_ADDR;
            err_count <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= '{word: enc_word, addr: addr_q, err: enc_err};
                wr_ptr_q        <= ~wr_ptr_q;
                addr_q          <= addr_q + 32'd4;
                if (enc_err && !(&err_count)) begin
                    err_count <= err_count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_encode.sv
// Directed bench for rv32i_encode: hand-computed encodings, address tagging, errors, backpressure, reset.
module tb_rv32i_encode;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    rv32i_encode #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    // Holds the request until accepted, bounded.
    task automatic push(input string tag, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        logic accepted;
        accepted = 1'b0;
        set_req(op, rd, rs1, rs2, imm);
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = in_ready;
            tick;
        end
        in_valid = 1'b0;
        checks++;
        assert (accepted) else begin
            errors++;
            $error("FAIL %s_accept: observed no accept expected accept within 20 cycles", tag);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] word, input logic [31:0] addr,
                             input logic err);
        logic seen;
        seen = out_valid;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick;
            seen = out_valid;
        end
        check({tag, "_valid"}, {31'd0, seen}, 32'd1);
        check({tag, "_word"}, out_word, word);
        check({tag, "_addr"}, out_addr, addr);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_req(6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        do_reset;

        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", out_word, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);

        // addi x1,x0,5: valid exactly one cycle after accept
        set_req(6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        tick;
        in_valid = 1'b0;
        check("addi_lat_valid", {31'd0, out_valid}, 32'd1);
        pop_check("addi", 32'h0050_0093, 32'h0, 1'b0);
        check("addi_drained", {31'd0, out_valid}, 32'd0);

        // Streaming with out_ready held high: push and pop share cycles
        do_reset;
        out_ready = 1'b1;
        set_req(6'd28, 5'd3, 5'd1, 5'd2, 32'd0);
        tick;
        check("sub_word", out_word, 32'h4020_81B3);
        check("sub_addr", out_addr, 32'h0);
        set_req(6'd26, 5'd1, 5'd1, 5'd0, 32'd3);
        tick;
        check("srai_word", out_word, 32'h4030_D093);
        check("srai_addr", out_addr, 32'h4);
        set_req(6'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        tick;
        in_valid = 1'b0;
        check("lui_word", out_word, 32'h1234_52B7);
        check("lui_addr", out_addr, 32'h8);
        check("lui_valid", {31'd0, out_valid}, 32'd1);
        tick;
        out_ready = 1'b0;
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        push("beq", 6'd4, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        push("jal", 6'd2, 5'd1, 5'd0, 5'd0, 32'd8);
        pop_check("beq", 32'hFE20_8EE3, 32'hC, 1'b0);
        pop_check("jal", 32'h0080_00EF, 32'h10, 1'b0);

        // Range errors leave address gaps
        do_reset;
        push("e_addi", 6'd18, 5'd1, 5'd0, 5'd0, 32'd2048);
        pop_check("e_addi", 32'h0, 32'h0, 1'b1);
        push("e_beq", 6'd4, 5'd0, 5'd1, 5'd2, 32'd3);
        pop_check("e_beq", 32'h0, 32'h4, 1'b1);
        push("e_slli", 6'd24, 5'd1, 5'd1, 5'd0, 32'd32);
        pop_check("e_slli", 32'h0, 32'h8, 1'b1);
        push("e_op40", 6'd40, 5'd1, 5'd1, 5'd1, 32'd0);
        pop_check("e_op40", 32'h0, 32'hC, 1'b1);
        check("err_count_4", {24'd0, err_count}, 32'd4);

        push("addi_max", 6'd18, 5'd2, 5'd0, 5'd7, 32'd2047);
        pop_check("addi_max", 32'h7FF0_0113, 32'h10, 1'b0);
        push("addi_min", 6'd18, 5'd2, 5'd0, 5'd0, 32'hFFFF_F800);
        pop_check("addi_min", 32'h8000_0113, 32'h14, 1'b0);
        push("sw", 6'd17, 5'd9, 5'd1, 5'd2, 32'hFFFF_FFFC);
        pop_check("sw", 32'hFE20_AE23, 32'h18, 1'b0);
        push("lw", 6'd12, 5'd3, 5'd1, 5'd0, 32'd8);
        pop_check("lw", 32'h0080_A183, 32'h1C, 1'b0);
        push("bgeu_max", 6'd9, 5'd0, 5'd1, 5'd2, 32'd4094);
        pop_check("bgeu_max", 32'h7E20_FFE3, 32'h20, 1'b0);
        push("e_b4096", 6'd4, 5'd0, 5'd1, 5'd2, 32'd4096);
        pop_check("e_b4096", 32'h0, 32'h24, 1'b1);
        push("e_lui", 6'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
        pop_check("e_lui", 32'h0, 32'h28, 1'b1);
        check("err_count_6", {24'd0, err_count}, 32'd6);

        // Backpressure: third request held while buffer is full
        push("bp_a", 6'd27, 5'd1, 5'd2, 5'd3, 32'd0);
        push("bp_b", 6'd36, 5'd4, 5'd5, 5'd6, 32'd0);
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        set_req(6'd34, 5'd7, 5'd8, 5'd9, 32'd0);
        tick;
        tick;
        check("bp_held_ready", {31'd0, in_ready}, 32'd0);
        check("bp_stable_word", out_word, 32'h0031_00B3);
        check("bp_stable_addr", out_addr, 32'h2C);
        out_ready = 1'b1;
        tick;
        check("bp_b_word", out_word, 32'h0062_F233);
        check("bp_b_addr", out_addr, 32'h30);
        check("bp_b_ready", {31'd0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
        check("bp_c_word", out_word, 32'h4094_53B3);
        check("bp_c_addr", out_addr, 32'h34);
        check("bp_c_valid", {31'd0, out_valid}, 32'd1);
        tick;
        out_ready = 1'b0;
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset with two words buffered
        push("r_a", 6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        push("r_b", 6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        check("r_full_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("r_out_valid", {31'd0, out_valid}, 32'd0);
        check("r_err_count", {24'd0, err_count}, 32'd0);
        check("r_in_ready", {31'd0, in_ready}, 32'd1);
        check("r_out_word", out_word, 32'h0);
        push("r_next", 6'd18, 5'd1, 5'd0, 5'd0, 32'd5);
        pop_check("r_next", 32'h0050_0093, 32'h0, 1'b0);

        // err_count saturates at all-ones
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            set_req(6'd63, 5'd0, 5'd0, 5'd0, 32'd0);
            tick;
        end
        in_valid = 1'b0;
        tick;
        out_ready = 1'b0;
        check("err_count_sat", {24'd0, err_count}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
